// File: rtl/datamem_arb_pkg.sv
// Shared types and sizes for the two-requester datamem arbiter.
package datamem_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned STATS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant: on a tie the requester not granted
// last wins; a single valid requester is granted directly.
module rr_arbiter2
  import datamem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-requester arbiter in front of a synchronous datamem (IDLE/ISSUE/RESP).
// Optional grant/conflict counters are enabled by defining DATAMEM_ARB_STATS_EN.
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_we,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]     req_x,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]     req_y,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  mem_we,
  output logic [ADDR_BITS-1:0]                  mem_x,
  output logic [ADDR_BITS-1:0]                  mem_y,
  output logic [DATA_WIDTH-1:0]                 mem_din,
`ifdef DATAMEM_ARB_STATS_EN
  output logic [STATS_W-1:0]                    grant_cnt0,
  output logic [STATS_W-1:0]                    grant_cnt1,
  output logic [STATS_W-1:0]                    conflict_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]                 mem_dout
);

  arb_state_e               state_q, state_d;
  logic                     last_q, last_d;
  logic                     owner_q, owner_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]     mem_x_q, mem_x_d;
  logic [ADDR_BITS-1:0]     mem_y_q, mem_y_d;
  logic [DATA_WIDTH-1:0]    mem_din_q, mem_din_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       accept;
  logic                     sel;

  rr_arbiter2 u_rr (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Grants are only offered in IDLE; a grant implies the matching valid.
  assign accept    = (state_q == IDLE) ? grant : '0;
  assign sel       = accept[1];
  assign req_ready = reset ? '0 : accept;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    mem_we_d    = 1'b0;
    mem_x_d     = mem_x_q;
    mem_y_d     = mem_y_q;
    mem_din_d   = mem_din_q;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: begin
        if (|accept) begin
          state_d   = ISSUE;
          last_d    = sel;
          owner_d   = sel;
          mem_we_d  = req_we[sel];
          mem_x_d   = req_x[sel];
          mem_y_d   = req_y[sel];
          mem_din_d = req_wdata[sel];
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d     = RESP;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_x_q     <= '0;
      mem_y_q     <= '0;
      mem_din_q   <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_x_q     <= mem_x_d;
      mem_y_q     <= mem_y_d;
      mem_din_q   <= mem_din_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Reset squashes an in-flight write and response in the very cycle it is seen.
  assign mem_we    = mem_we_q & ~reset;
  assign mem_x     = mem_x_q;
  assign mem_y     = mem_y_q;
  assign mem_din   = mem_din_q;
  assign rsp_valid = reset ? '0 : rsp_valid_q;
  assign rsp_rdata = (|rsp_valid_q) ? mem_dout : '0;

`ifdef DATAMEM_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [STATS_W-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [STATS_W-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    grant_cnt0_d   = accept[0] ? sat_inc(grant_cnt0_q) : grant_cnt0_q;
    grant_cnt1_d   = accept[1] ? sat_inc(grant_cnt1_q) : grant_cnt1_q;
    conflict_cnt_d = ((state_q == IDLE) && (&req_valid)) ? sat_inc(conflict_cnt_q)
                                                          : conflict_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed self-checking bench for datamem_arbiter with a behavioural datamem.
// Define DATAMEM_ARB_STATS_EN to also exercise the statistics counters.
module tb_datamem_arbiter;

  localparam int unsigned AB = 4;
  localparam int unsigned DW = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_we;
  logic [1:0][AB-1:0]    req_x;
  logic [1:0][AB-1:0]    req_y;
  logic [1:0][DW-1:0]    req_wdata;
  logic [1:0]            rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  mem_we;
  logic [AB-1:0]         mem_x;
  logic [AB-1:0]         mem_y;
  logic [DW-1:0]         mem_din;
  logic [DW-1:0]         mem_dout;
`ifdef DATAMEM_ARB_STATS_EN
  logic [15:0]           grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  datamem_arbiter #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_we       (mem_we),
    .mem_x        (mem_x),
    .mem_y        (mem_y),
    .mem_din      (mem_din),
`ifdef DATAMEM_ARB_STATS_EN
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt),
`endif
    .mem_dout     (mem_dout)
  );

  // Synchronous datamem: write on edge, read data valid the following cycle.
  logic [DW-1:0] mem_arr [16][16];
  initial begin
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        mem_arr[i][j] = '0;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_x][mem_y] <= mem_din;
    mem_dout <= mem_arr[mem_x][mem_y];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one request (caller sits just after a negedge) and wait for its
  // acceptance; returns just after the negedge of the ISSUE cycle.
  task automatic issue(input int id, input logic we, input logic [AB-1:0] x,
                       input logic [AB-1:0] y, input logic [DW-1:0] d);
    bit ok = 1'b0;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    req_x[id]     = x;
    req_y[id]     = y;
    req_wdata[id] = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = '0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req_valid[id] = 1'b0;
    end
  endtask

  // Hold both requesters valid with reads until n transfers are accepted.
  task automatic contend(input int n, output int got, output int gs[8], output int cs[8]);
    int cyc = 0;
    got = 0;
    for (int k = 0; k < 8; k++) begin gs[k] = -1; cs[k] = -1; end
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_x[0]  = 4'd3; req_y[0] = 4'd5;
    req_x[1]  = 4'd1; req_y[1] = 4'd1;
    for (int i = 0; i < 40 && got < n; i++) begin
      #1;
      if (|req_ready) begin
        gs[got] = int'(req_ready[1]);
        cs[got] = cyc;
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int got;
    int gs[8];
    int cs[8];
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};

    reset     = 1'b1;
    req_valid = 2'b11;
    req_we    = '0;
    req_x     = '0;
    req_y     = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_x", 32'(mem_x), 32'd0);
    chk("rst_mem_y", 32'(mem_y), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    reset     = 1'b0;
    req_valid = '0;
    @(negedge clk);

    // Write from requester 0.
    issue(0, 1'b1, 4'd3, 4'd5, 8'hA5);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_x", 32'(mem_x), 32'd3);
    chk("wr_mem_y", 32'(mem_y), 32'd5);
    chk("wr_mem_din", 32'(mem_din), 32'hA5);
    chk("wr_rsp_none", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("wr_we_one_cycle", 32'(mem_we), 32'd0);
    chk("wr_rsp_none2", 32'(rsp_valid), 32'd0);
    chk("idle_hold_x", 32'(mem_x), 32'd3);
    chk("idle_hold_din", 32'(mem_din), 32'hA5);

    // Read back from requester 1.
    issue(1, 1'b0, 4'd3, 4'd5, 8'h00);
    chk("rd_issue_we", 32'(mem_we), 32'd0);
    chk("rd_issue_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'b10);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    @(negedge clk);
    chk("rd_rsp_one_cycle", 32'(rsp_valid), 32'd0);

    // Contended reads alternate, three cycles apart.
    contend(6, got, gs, cs);
    chk("rr_count", 32'(got), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_grant%0d", k), 32'(gs[k]), 32'(exp_g[k]));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(cs[k] - cs[k-1]), 32'd3);
    end

    // Request fields changed after acceptance must not leak into the access.
    issue(0, 1'b1, 4'd2, 4'd1, 8'h5A);
    req_x[0] = 4'd7;
    #1;
    chk("late_change_x", 32'(mem_x), 32'd2);
    chk("late_change_din", 32'(mem_din), 32'h5A);
    @(negedge clk);
    chk("late_change_idle_x", 32'(mem_x), 32'd2);

    // Reset during the ISSUE cycle of a write discards it.
    issue(0, 1'b1, 4'd0, 4'd0, 8'h11);
    reset = 1'b1;
    #1;
    chk("rst_issue_we", 32'(mem_we), 32'd0);
    chk("rst_issue_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b10;
    req_we[1] = 1'b0;
    req_x[1]  = 4'd0;
    req_y[1]  = 4'd0;
    #1;
    chk("rst_back_idle", 32'(req_ready), 32'b10);
    chk("rst_clr_x", 32'(mem_x), 32'd0);
    issue(1, 1'b0, 4'd0, 4'd0, 8'h00);
    @(negedge clk);
    chk("rst_rd_valid", 32'(rsp_valid), 32'b10);
    chk("rst_rd_data", 32'(rsp_rdata), 32'h00);
    @(negedge clk);

`ifdef DATAMEM_ARB_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("st_clr_g0", 32'(grant_cnt0), 32'd0);
    chk("st_clr_g1", 32'(grant_cnt1), 32'd0);
    chk("st_clr_cf", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    contend(4, got, gs, cs);
    chk("st_count", 32'(got), 32'd4);
    chk("st_g0", 32'(grant_cnt0), 32'd2);
    chk("st_g1", 32'(grant_cnt1), 32'd2);
    chk("st_conflict", 32'(conflict_cnt), 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
